// File: rtl/fpu_writeback_stage.sv
// fpu_writeback_stage: tracks one in-flight FPU op, holds its result for regfile writeback,
// accrues sticky fflags and raises a sticky watchdog error on a missing completion.
module fpu_writeback_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [RD_W-1:0]   issue_rd,
  input  logic              issue_to_int,
  input  logic              fpu_done,
  input  logic [DATA_W-1:0] fpu_result,
  input  logic              fpu_nv,
  input  logic              fpu_dz,
  input  logic              fpu_of,
  input  logic              fpu_uf,
  input  logic              fpu_nx,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_to_int,
  input  logic              csr_fflags_we,
  input  logic [4:0]        csr_fflags_wdata,
  output logic [4:0]        fflags,
  output logic              watchdog_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_inc;
  logic [RD_W-1:0] tag_rd;
  logic tag_to_int;
  logic [4:0] held_flags;
  logic hs, issue_go, run, timeout, capture, enter_run;
  assign wb_valid = state == HOLD;
  assign issue_ready = state == IDLE || (state == HOLD && wb_ready);
  assign hs = wb_valid && wb_ready;
  assign issue_go = issue_valid && issue_ready && !flush;
  assign run = state == BUSY || state == DRAIN;
  assign cnt_inc = cnt == TMAX ? cnt : cnt + CW'(1);
  // a completion arriving on the timeout cycle still wins over the watchdog
  assign timeout = run && !fpu_done && !(state == BUSY && flush) && cnt_inc == TMAX;
  assign capture = state == BUSY && fpu_done && !flush;
  assign enter_run = (state_nxt == BUSY && state != BUSY) || (state_nxt == DRAIN && state != DRAIN);
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = issue_go ? BUSY : IDLE;
      BUSY:  state_nxt = fpu_done ? (flush ? IDLE : HOLD) : flush ? DRAIN : timeout ? IDLE : BUSY;
      HOLD:  state_nxt = hs ? (issue_go ? BUSY : IDLE) : flush ? IDLE : HOLD;
      DRAIN: state_nxt = (fpu_done || timeout) ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tag_rd <= '0;
      tag_to_int <= 1'b0;
      held_flags <= '0;
      wb_data <= '0;
      wb_rd <= '0;
      wb_to_int <= 1'b0;
      fflags <= '0;
      watchdog_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= enter_run ? '0 : run ? cnt_inc : cnt;
      if (issue_go) begin
        tag_rd <= issue_rd;
        tag_to_int <= issue_to_int;
      end
      if (capture) begin
        wb_data <= fpu_result;
        wb_rd <= tag_rd;
        wb_to_int <= tag_to_int;
        held_flags <= {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx};
      end
      if (timeout) watchdog_err <= 1'b1;
      fflags <= (csr_fflags_we ? csr_fflags_wdata : fflags) | (hs ? held_flags : 5'b0);
    end
  end
endmodule

// File: tb/tb_fpu_writeback_stage.sv
// tb_fpu_writeback_stage: directed checks of issue/capture/writeback, flag accrual, flush and watchdog.
module tb_fpu_writeback_stage;
  logic clk = 0, reset = 1;
  logic issue_valid = 0, issue_ready, issue_to_int = 0;
  logic [4:0] issue_rd = 0;
  logic fpu_done = 0;
  logic [31:0] fpu_result = 0;
  logic fpu_nv = 0, fpu_dz = 0, fpu_of = 0, fpu_uf = 0, fpu_nx = 0;
  logic flush = 0, wb_valid, wb_ready = 0, wb_to_int;
  logic [31:0] wb_data;
  logic [4:0] wb_rd, fflags;
  logic csr_fflags_we = 0;
  logic [4:0] csr_fflags_wdata = 0;
  logic watchdog_err;
  int checks = 0, failures = 0;
  fpu_writeback_stage dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_to_int(issue_to_int), .fpu_done(fpu_done), .fpu_result(fpu_result),
    .fpu_nv(fpu_nv), .fpu_dz(fpu_dz), .fpu_of(fpu_of), .fpu_uf(fpu_uf), .fpu_nx(fpu_nx),
    .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_to_int(wb_to_int), .csr_fflags_we(csr_fflags_we), .csr_fflags_wdata(csr_fflags_wdata),
    .fflags(fflags), .watchdog_err(watchdog_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_flags(input logic [4:0] f);
    {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = f;
  endtask
  // issue one op, complete it on the next cycle; leaves the stage in HOLD
  task automatic run_op(input logic [4:0] rd, input logic to_int, input logic [31:0] res, input logic [4:0] f);
    issue_valid = 1; issue_rd = rd; issue_to_int = to_int;
    tick;
    issue_valid = 0;
    fpu_done = 1; fpu_result = res; set_flags(f);
    tick;
    fpu_done = 0; set_flags(5'b0);
  endtask
  initial begin
    tick; tick;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_wd", watchdog_err, 0);
    reset = 0;
    // single op, done four cycles after issue
    issue_valid = 1; issue_rd = 5; issue_to_int = 0;
    tick;
    issue_valid = 0;
    chk("busy_issue_ready", issue_ready, 0);
    chk("busy_wb_valid", wb_valid, 0);
    tick; tick; tick;
    fpu_done = 1; fpu_result = 32'h3F800000; set_flags(5'b00001); wb_ready = 1;
    tick;
    fpu_done = 0; set_flags(5'b0);
    chk("op1_wb_valid", wb_valid, 1);
    chk("op1_wb_data", wb_data, 32'h3F800000);
    chk("op1_wb_rd", wb_rd, 5);
    chk("op1_fflags_at_capture", fflags, 0);
    tick;
    chk("op1_wb_valid_drop", wb_valid, 0);
    chk("op1_fflags", fflags, 5'b00001);
    // back-pressure then back-to-back issue in the handshake cycle
    wb_ready = 0;
    run_op(7, 1, 32'h40490FDB, 5'b00010);
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1; issue_rd = 9;
      chk("bp_wb_valid", wb_valid, 1);
      chk("bp_wb_data", wb_data, 32'h40490FDB);
      chk("bp_wb_rd", wb_rd, 7);
      chk("bp_wb_to_int", wb_to_int, 1);
      chk("bp_issue_ready", issue_ready, 0);
      chk("bp_fflags", fflags, 5'b00001);
      tick;
    end
    wb_ready = 1; issue_valid = 1; issue_rd = 9; issue_to_int = 0;
    #1 chk("b2b_issue_ready", issue_ready, 1);
    tick;
    issue_valid = 0;
    chk("b2b_busy_wb_valid", wb_valid, 0);
    chk("b2b_busy_issue_ready", issue_ready, 0);
    chk("b2b_fflags", fflags, 5'b00011);
    fpu_done = 1; fpu_result = 32'h11; set_flags(5'b00100);
    tick;
    fpu_done = 0; set_flags(5'b0);
    chk("b2b_wb_rd", wb_rd, 9);
    chk("b2b_wb_to_int", wb_to_int, 0);
    tick;
    chk("b2b_fflags_after", fflags, 5'b00111);
    // flag accrual and CSR write
    csr_fflags_we = 1; csr_fflags_wdata = 0;
    tick;
    csr_fflags_we = 0;
    chk("csr_clear", fflags, 0);
    run_op(1, 0, 32'h1, 5'b00100);
    tick;
    run_op(2, 0, 32'h2, 5'b01000);
    tick;
    chk("accrue_dz_of", fflags, 5'b01100);
    wb_ready = 0;
    run_op(3, 0, 32'h3, 5'b10000);
    wb_ready = 1; csr_fflags_we = 1; csr_fflags_wdata = 0;
    tick;
    csr_fflags_we = 0;
    chk("csr_with_hs", fflags, 5'b10000);
    // flush in BUSY, done arrives two cycles later and is drained
    issue_valid = 1; issue_rd = 4;
    tick;
    issue_valid = 0; flush = 1;
    tick;
    flush = 0;
    chk("drain_issue_ready", issue_ready, 0);
    tick;
    fpu_done = 1; fpu_nv = 1; fpu_result = 32'hDEAD;
    tick;
    fpu_done = 0; set_flags(5'b0);
    chk("drain_wb_valid", wb_valid, 0);
    chk("drain_ready_back", issue_ready, 1);
    chk("drain_fflags", fflags, 5'b10000);
    // flush in HOLD discards the entry
    wb_ready = 0;
    run_op(8, 0, 32'hBEEF, 5'b00001);
    flush = 1;
    tick;
    flush = 0; wb_ready = 1;
    chk("hold_flush_wb_valid", wb_valid, 0);
    tick;
    chk("hold_flush_fflags", fflags, 5'b10000);
    // spurious done in IDLE is ignored
    fpu_done = 1; fpu_dz = 1;
    tick;
    fpu_done = 0; set_flags(5'b0);
    chk("spurious_wb_valid", wb_valid, 0);
    tick;
    chk("spurious_fflags", fflags, 5'b10000);
    // done on the timeout cycle wins
    wb_ready = 0; issue_valid = 1; issue_rd = 10;
    tick;
    issue_valid = 0;
    repeat (63) tick;
    fpu_done = 1; fpu_result = 32'h77;
    tick;
    fpu_done = 0;
    chk("edge_done_wb_valid", wb_valid, 1);
    chk("edge_done_wd", watchdog_err, 0);
    wb_ready = 1;
    tick;
    // watchdog timeout
    issue_valid = 1; issue_rd = 11;
    tick;
    issue_valid = 0;
    repeat (63) tick;
    chk("wd_before", watchdog_err, 0);
    chk("wd_before_ready", issue_ready, 0);
    tick;
    chk("wd_err", watchdog_err, 1);
    chk("wd_ready", issue_ready, 1);
    run_op(3, 0, 32'h55, 5'b00001);
    chk("wd_later_wb_valid", wb_valid, 1);
    chk("wd_later_data", wb_data, 32'h55);
    tick;
    chk("wd_later_fflags", fflags, 5'b10001);
    chk("wd_sticky", watchdog_err, 1);
    // reset mid-HOLD
    csr_fflags_we = 1; csr_fflags_wdata = 5'b11111; wb_ready = 0;
    tick;
    csr_fflags_we = 0;
    run_op(6, 1, 32'hAA, 5'b0);
    chk("pre_rst_wb_valid", wb_valid, 1);
    chk("pre_rst_fflags", fflags, 5'b11111);
    reset = 1;
    tick;
    reset = 0;
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_wb_data", wb_data, 0);
    chk("mid_rst_wb_rd", wb_rd, 0);
    chk("mid_rst_wb_to_int", wb_to_int, 0);
    chk("mid_rst_fflags", fflags, 0);
    chk("mid_rst_wd", watchdog_err, 0);
    chk("mid_rst_issue_ready", issue_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_writeback_stage.md
Name: fpu_writeback_stage

Overview:
- Sits directly downstream of the FPU arithmetic top level.
- Tracks one in-flight FPU operation from issue to completion, and captures the result and exception flags on the done pulse.
- Presents the captured result to the register-file writeback port with a valid/ready handshake.
- Maintains the sticky RISC-V fflags CSR, and drives issue back-pressure and a completion watchdog for the core pipeline.

Parameters:
- DATA_W, 32, result width
- RD_W, 5, destination register index width
- TIMEOUT_CYCLES, 64, maximum cycles from issue to done before watchdog error

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  core issues an FPU op this cycle (same cycle as FPU start)
- issue_ready  out  1  stage can accept an issue
- issue_rd  in  RD_W  destination register of issued op
- issue_to_int  in  1  result targets integer regfile (compare/classify/fmv.x.w/fcvt.w)
- fpu_done  in  1  FPU completion pulse
- fpu_result  in  DATA_W  FPU result, valid when fpu_done
- fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx  in  1 each  invalid, div_by_zero, overflow, underflow, inexact
- flush  in  1  kill in-flight/held op (branch mispredict, trap)
- wb_valid  out  1  held result available
- wb_ready  in  1  regfile write port accepts
- wb_data  out  DATA_W  held result
- wb_rd  out  RD_W  held destination
- wb_to_int  out  1  held target-file select
- csr_fflags_we  in  1  CSR write to fflags/fcsr
- csr_fflags_wdata  in  5  new fflags value
- fflags  out  5  accrued flags {NV,DZ,OF,UF,NX}, bit4..bit0
- watchdog_err  out  1  sticky timeout error

Behaviour:
- Reset (synchronous, active-high; every output and register clears on the clk edge while reset=1):
  - state=IDLE, issue_ready=1, wb_valid=0, wb_data=0, wb_rd=0, wb_to_int=0, fflags=0, watchdog_err=0, counter=0.
- States and transitions:
  - IDLE -> BUSY on issue_valid. issue_rd and issue_to_int latch into the tag registers.
  - BUSY -> HOLD on fpu_done. fpu_result and the five flags latch. wb_valid=1 from the next cycle, so latency is done-edge plus 1 cycle.
  - HOLD -> IDLE on wb_valid&&wb_ready with no issue_valid.
  - HOLD -> BUSY on wb_valid&&wb_ready&&issue_valid (back-to-back), with the new tag latched.
- issue_ready = (state==IDLE) || (state==HOLD && wb_ready). issue_valid while issue_ready=0 is ignored, and state is unchanged.
- fpu_done while in IDLE or HOLD (spurious) is ignored; no capture and no flag update.
- wb_data, wb_rd and wb_to_int stay stable while wb_valid=1 and wb_ready=0.
- Flag accrual:
  - Held flags OR into fflags only on the writeback handshake (wb_valid&&wb_ready), never at capture.
  - csr_fflags_we alone: fflags <= csr_fflags_wdata.
  - csr_fflags_we in the same cycle as a handshake: fflags <= csr_fflags_wdata | held_flags.
- Flush:
  - In BUSY: go to DRAIN. In DRAIN, the next fpu_done is discarded (no capture, no flags), then go to IDLE. issue_ready=0 in DRAIN.
  - In HOLD: discard the entry; wb_valid=0 next cycle; no flag accrual; go to IDLE.
  - flush and handshake in the same cycle: the handshake wins (the write retires), then flush applies to nothing.
  - flush in IDLE: no effect.
  - flush and issue_valid in the same cycle: the issue is dropped.
- Watchdog:
  - Counter clears on entry to BUSY/DRAIN and increments each BUSY/DRAIN cycle.
  - When it reaches TIMEOUT_CYCLES: watchdog_err=1 (sticky until reset), state -> IDLE, and the op is abandoned.
  - The counter saturates and does not wrap.
- fpu_done in the same cycle as the timeout: done wins; capture normally, no error.

Test Plan:
- Single op: issue rd=5, done 4 cycles later with result 0x3F800000 and nx=1, wb_ready=1 -> wb_valid high for exactly 1 cycle, 1 cycle after done; wb_rd=5; fflags=5'b00001 after the handshake.
- Back-pressure: wb_ready=0 for 3 cycles after capture -> wb_data held at 0x40490FDB; issue_ready=0; fflags unchanged until wb_ready=1; back-to-back issue accepted in the handshake cycle.
- Flag accrual: two ops with dz then of -> fflags=5'b01100. CSR write 0 in the same cycle as a handshake of an nv op -> fflags=5'b10000.
- Flush in BUSY: done arrives 2 cycles after flush with inv=1 -> wb_valid stays 0, fflags unchanged, issue_ready returns to 1 the cycle after done.
- Watchdog: issue with no done for 64 cycles -> watchdog_err=1, state returns to IDLE, issue_ready=1. A later op completes normally and watchdog_err stays 1.
- Reset mid-HOLD with wb_valid=1 and fflags=5'b11111 -> all outputs 0 the cycle after reset; issue_ready=1.
